// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: exception causes, the NOP encoding,
// the fetch-buffer entry layout and the fetch state encoding.
package cpu_pkg;

  localparam logic [3:0]  EXC_INSTR_MISALIGNED   = 4'd0;
  localparam logic [3:0]  EXC_INSTR_ACCESS_FAULT = 4'd1;
  localparam logic [31:0] NOP_INSTR              = 32'h00000013;
  localparam int          FETCH_ENTRY_W          = 64 + 32 + 1 + 4 + 64;

  typedef enum logic {
    ST_FETCH    = 1'b0,
    ST_HOLD_EXC = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
    logic        exc_en;
    logic [3:0]  exc_code;
    logic [63:0] exc_val;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO for fetched entries; flush dominates push and pop.
// A push into a full FIFO is accepted only when the head is popped in the same cycle.
module fetch_fifo #(
  parameter int WIDTH = 165,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && (!full || do_pop) && !flush;
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC, buffers fetched entries for decode.
// Define FETCH_PERF_EN to add the perf_fetch_cnt / perf_stall_cnt counters.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [63:0] RESET_PC   = 64'h0,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [63:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        imem_exc_en,
  input  logic [3:0]  imem_exc_code,
  input  logic [63:0] imem_exc_val,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_pc,
  output logic [31:0] out_instr,
  output logic        out_exc_en,
  output logic [3:0]  out_exc_code,
  output logic [63:0] out_exc_val
`ifdef FETCH_PERF_EN
  ,
  output logic [63:0] perf_fetch_cnt,
  output logic [63:0] perf_stall_cnt
`endif
);

  fetch_state_e state_q, state_d;
  logic [63:0]  pc_q, pc_d;
  fetch_entry_t push_entry, head_entry;
  logic [FETCH_ENTRY_W-1:0] head_bits;
  logic         fifo_full, fifo_empty;
  logic         pop, enq;

  assign imem_addr = pc_q;
  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;
  assign enq       = (state_q == ST_FETCH) && (!fifo_full || pop);
  assign head_entry = fetch_entry_t'(head_bits);

  // Misalignment is checked first: memory data for an unaligned PC is not trusted.
  always_comb begin
    push_entry.pc       = pc_q;
    push_entry.instr    = imem_instr;
    push_entry.exc_en   = imem_exc_en;
    push_entry.exc_code = imem_exc_code;
    push_entry.exc_val  = imem_exc_val;
    if (pc_q[1:0] != 2'b00) begin
      push_entry.instr    = NOP_INSTR;
      push_entry.exc_en   = 1'b1;
      push_entry.exc_code = EXC_INSTR_MISALIGNED;
      push_entry.exc_val  = pc_q;
    end else if (imem_exc_en) begin
      push_entry.instr    = NOP_INSTR;
    end
  end

  always_comb begin
    pc_d    = pc_q;
    state_d = state_q;
    if (redirect_valid) begin
      pc_d    = redirect_pc;
      state_d = ST_FETCH;
    end else if (enq) begin
      if (push_entry.exc_en) state_d = ST_HOLD_EXC;
      else                   pc_d    = pc_q + 64'd4;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      state_q <= ST_FETCH;
    end else begin
      pc_q    <= pc_d;
      state_q <= state_d;
    end
  end

  fetch_fifo #(
    .WIDTH (FETCH_ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (enq),
    .pop   (pop),
    .flush (redirect_valid),
    .din   (push_entry),
    .dout  (head_bits),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // An empty buffer presents the reset values rather than stale storage.
  always_comb begin
    out_pc       = 64'h0;
    out_instr    = NOP_INSTR;
    out_exc_en   = 1'b0;
    out_exc_code = 4'h0;
    out_exc_val  = 64'h0;
    if (!fifo_empty) begin
      out_pc       = head_entry.pc;
      out_instr    = head_entry.instr;
      out_exc_en   = head_entry.exc_en;
      out_exc_code = head_entry.exc_code;
      out_exc_val  = head_entry.exc_val;
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetch_cnt <= 64'h0;
      perf_stall_cnt <= 64'h0;
    end else if (!redirect_valid) begin
      if (enq)                                 perf_fetch_cnt <= perf_fetch_cnt + 64'd1;
      else if (state_q == ST_FETCH)            perf_stall_cnt <= perf_stall_cnt + 64'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: queue-based reference model plus directed checks.
module tb_fetch_unit;
  import cpu_pkg::*;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] imem_addr;
  logic [31:0] imem_instr;
  logic        imem_exc_en;
  logic [3:0]  imem_exc_code;
  logic [63:0] imem_exc_val;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = 64'h0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] out_pc;
  logic [31:0] out_instr;
  logic        out_exc_en;
  logic [3:0]  out_exc_code;
  logic [63:0] out_exc_val;
`ifdef FETCH_PERF_EN
  logic [63:0] perf_fetch_cnt;
  logic [63:0] perf_stall_cnt;
`endif

  logic        fault_on = 1'b0;
  logic [63:0] fault_addr = 64'h0;
  logic [63:0] fault_val = 64'h0;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(64'h0), .FIFO_DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .imem_exc_en    (imem_exc_en),
    .imem_exc_code  (imem_exc_code),
    .imem_exc_val   (imem_exc_val),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr      (out_instr),
    .out_exc_en     (out_exc_en),
    .out_exc_code   (out_exc_code),
    .out_exc_val    (out_exc_val)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    if (a == 64'h0)      return 32'h00500093;
    else if (a == 64'h4) return 32'h00a00113;
    else                 return a[31:0] ^ 32'h5A5A0003;
  endfunction

  // Instruction memory: combinational, with one optional faulting address.
  always_comb begin
    imem_instr    = mem_word(imem_addr);
    imem_exc_en   = fault_on && (imem_addr == fault_addr);
    imem_exc_code = imem_exc_en ? EXC_INSTR_ACCESS_FAULT : 4'h0;
    imem_exc_val  = imem_exc_en ? fault_val : 64'h0;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the buffer is a plain queue, the PC an integer that either
  // advances by four, jumps on redirect, or freezes after a faulting fetch.
  fetch_entry_t q[$];
  logic [63:0]  m_pc = 64'h0;
  bit           m_hold = 1'b0;
  longint unsigned m_fetch = 0, m_stall = 0;
  bit           started = 1'b0;

  always @(posedge clk) begin
    fetch_entry_t e;
    bit popped, can;
    started = 1'b1;
    if (rst) begin
      q.delete();
      m_pc = 64'h0; m_hold = 1'b0; m_fetch = 0; m_stall = 0;
    end else if (redirect_valid) begin
      q.delete();
      m_pc = redirect_pc; m_hold = 1'b0;
    end else begin
      popped = (q.size() > 0) && out_ready;
      can    = !m_hold && ((q.size() < DEPTH) || popped);
      if (popped) void'(q.pop_front());
      if (can) begin
        m_fetch++;
        if (m_pc[1:0] != 2'b00) begin
          e = '{pc: m_pc, instr: NOP_INSTR, exc_en: 1'b1, exc_code: EXC_INSTR_MISALIGNED, exc_val: m_pc};
          m_hold = 1'b1;
        end else if (fault_on && m_pc == fault_addr) begin
          e = '{pc: m_pc, instr: NOP_INSTR, exc_en: 1'b1, exc_code: EXC_INSTR_ACCESS_FAULT, exc_val: fault_val};
          m_hold = 1'b1;
        end else begin
          e = '{pc: m_pc, instr: mem_word(m_pc), exc_en: 1'b0, exc_code: 4'h0, exc_val: 64'h0};
          m_pc = m_pc + 64'd4;
        end
        q.push_back(e);
      end else if (!m_hold) begin
        m_stall++;
      end
    end
  end

  // Compare the DUT against the model every cycle, away from the active edge.
  always @(negedge clk) begin
    if (started) begin
      chk("imem_addr", imem_addr, m_pc);
      chk("out_valid", {63'h0, out_valid}, {63'h0, q.size() > 0});
      if (q.size() > 0) begin
        chk("out_pc", out_pc, q[0].pc);
        chk("out_instr", {32'h0, out_instr}, {32'h0, q[0].instr});
        chk("out_exc_en", {63'h0, out_exc_en}, {63'h0, q[0].exc_en});
        chk("out_exc_code", {60'h0, out_exc_code}, {60'h0, q[0].exc_code});
        chk("out_exc_val", out_exc_val, q[0].exc_val);
      end else begin
        chk("idle_pc", out_pc, 64'h0);
        chk("idle_instr", {32'h0, out_instr}, {32'h0, NOP_INSTR});
        chk("idle_exc", {59'h0, out_exc_en, out_exc_code}, 64'h0);
        chk("idle_val", out_exc_val, 64'h0);
      end
`ifdef FETCH_PERF_EN
      chk("perf_fetch", perf_fetch_cnt, m_fetch);
      chk("perf_stall", perf_stall_cnt, m_stall);
`endif
    end
  end

  task automatic redirect_to(input logic [63:0] target);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    @(negedge clk);
    redirect_valid = 1'b0;
    chk("redir_bubble", {63'h0, out_valid}, 64'h0);
  endtask

  task automatic wait_head(input string name, input logic [63:0] pc, input int budget);
    bit found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge clk);
      if (out_valid && out_pc == pc) found = 1'b1;
    end
    chk(name, {63'h0, found}, 64'h1);
  endtask

  initial begin
    // Reset, streaming with out_ready high.
    rst = 1'b1; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_valid", {63'h0, out_valid}, 64'h0);
    chk("rst_addr", imem_addr, 64'h0);
    chk("rst_instr", {32'h0, out_instr}, 64'h00000013);
    @(negedge clk);
    chk("first_valid", {63'h0, out_valid}, 64'h1);
    chk("first_pc", out_pc, 64'h0);
    chk("first_instr", {32'h0, out_instr}, 64'h00500093);
    @(negedge clk);
    chk("second_pc", out_pc, 64'h4);
    chk("second_instr", {32'h0, out_instr}, 64'h00a00113);
    chk("second_exc", {63'h0, out_exc_en}, 64'h0);

    // Backpressure from reset: two entries held, fetch stalls at 0x8.
    rst = 1'b1; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("stall_addr", imem_addr, 64'h8);
    chk("stall_head", out_pc, 64'h0);
`ifdef FETCH_PERF_EN
    chk("stall_cnt", perf_stall_cnt, 64'd3);
`endif
    out_ready = 1'b1;
    @(negedge clk);
    chk("drain_pc4", out_pc, 64'h4);
    @(negedge clk);
    chk("drain_pc8", out_pc, 64'h8);

    // Access fault at 0x2000 freezes fetch until redirect.
    fault_on = 1'b1; fault_addr = 64'h2000; fault_val = 64'h2000;
    redirect_to(64'h1FF8);
    wait_head("fault_seen", 64'h2000, 10);
    chk("fault_instr", {32'h0, out_instr}, 64'h00000013);
    chk("fault_code", {60'h0, out_exc_code}, 64'h1);
    chk("fault_val", out_exc_val, 64'h2000);
    repeat (3) @(negedge clk);
    chk("fault_frozen_addr", imem_addr, 64'h2000);
    chk("fault_no_more", {63'h0, out_valid}, 64'h0);
    fault_on = 1'b0;
    redirect_to(64'h100);
    wait_head("after_fault", 64'h100, 4);

    // Redirect while full with a same-cycle pop.
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("full_valid", {63'h0, out_valid}, 64'h1);
    out_ready = 1'b1;
    redirect_to(64'h40);
    @(negedge clk);
    chk("redir_first", out_pc, 64'h40);

    // Misaligned target.
    redirect_to(64'h42);
    @(negedge clk);
    chk("mis_pc", out_pc, 64'h42);
    chk("mis_exc", {63'h0, out_exc_en}, 64'h1);
    chk("mis_code", {60'h0, out_exc_code}, 64'h0);
    chk("mis_val", out_exc_val, 64'h42);
    repeat (2) @(negedge clk);
    chk("mis_hold_valid", {63'h0, out_valid}, 64'h0);
    chk("mis_hold_addr", imem_addr, 64'h42);

    // PC wrap-around.
    redirect_to(64'hFFFF_FFFF_FFFF_FFFC);
    @(negedge clk);
    chk("wrap_head", out_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("wrap_addr", imem_addr, 64'h0);
    @(negedge clk);
    chk("wrap_next", out_pc, 64'h0);

    // Reset with entries queued.
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_rst_valid", {63'h0, out_valid}, 64'h1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_valid", {63'h0, out_valid}, 64'h0);
    chk("midrst_addr", imem_addr, 64'h0);
    out_ready = 1'b1;
    repeat (4) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

endmodule
